mips_mc_fetch_unit: RTL and testbench
=====================================

Name: mips_mc_fetch_unit

Overview:
- Multicycle MIPS datapath front-end, directly downstream of the multicycle main decoder/controller.
- Consumes the decoder's PCWrite, Branch, IRWrite, IorD and PCSrc outputs.
- Owns the PC, the instruction register (IR) and the memory data register (MDR).
- Drives the unified instruction/data memory read port through a ready/valid handshake and produces a Stall that freezes all architectural writes while memory is busy.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, watchdog limit in BUSY cycles (used only with the optional feature).

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- PCWrite  in  1  unconditional PC write from controller
- Branch  in  1  conditional PC write from controller (qualified by Zero)
- Zero  in  1  ALU zero flag
- IRWrite  in  1  load IR from memory read data
- IorD  in  1  memory address select: 0 = PC, 1 = ALUOut
- PCSrc  in  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target, 11 = hold
- MemReq  in  1  controller requests a memory read this state
- ALUResult  in  32  combinational ALU output
- ALUOut  in  32  registered ALU output
- MemRData  in  32  memory read data
- MemReady  in  1  memory returns data this cycle
- MemAddr  out  32  memory address
- MemRead  out  1  read strobe
- PC  out  32  current PC
- Instr  out  32  IR contents
- Data  out  32  MDR contents
- Stall  out  1  memory wait; controller must hold its state
- MemErr  out  1  sticky watchdog error (0 when the feature is compiled out)

Behaviour:
- Reset (async) forces:
  - PC = RESET_PC; Instr = 0; Data = 0; MemErr = 0.
  - Handshake state = IDLE; address latch = 0.
- Handshake FSM, two states, IDLE and BUSY:
  - MemRead = MemReq | (state == BUSY).
  - Stall = MemRead & ~MemReady (combinational).
  - IDLE: MemAddr = IorD ? ALUOut : PC (combinational).
    - MemReq & MemReady: zero-wait completion; read captured this edge; stay IDLE.
    - MemReq & ~MemReady: latch MemAddr; go BUSY.
  - BUSY: MemAddr = latched address, stable regardless of IorD/PC changes.
    - Stays BUSY until MemReady; the completion edge returns to IDLE.
    - MemReq is ignored while BUSY; the controller holds it via Stall.
- Completion edge (MemRead & MemReady):
  - Data <= MemRData.
  - Instr <= MemRData if IRWrite.
- IRWrite without a completing read (Stall = 1) does not modify Instr.
- PC write:
  - PCEn = (PCWrite | (Branch & Zero)) & ~Stall.
  - On PCEn, PC <= next-PC selected by PCSrc.
  - Jump target = {PC[31:28], Instr[25:0], 2'b00}.
  - PCSrc = 11 with PCEn leaves PC unchanged.
- Simultaneous PCWrite and Branch: PCWrite dominates; one write, same source.
- PC write and memory read in the same non-stalled cycle:
  - MemAddr uses the old PC.
  - The PC update takes effect at the same edge.
- Reset asserted mid-BUSY: the transaction is abandoned; no capture; IDLE on release.
- PC arithmetic is done entirely in the ALU; this block performs no addition. PC wraps naturally through the ALU result.

Optional Feature:
- Macro: MIPS_MC_FETCH_WATCHDOG_EN.
- With the macro:
  - An 8-bit counter counts consecutive BUSY cycles; it is cleared on entry to BUSY.
  - When the counter reaches TIMEOUT_CYCLES without MemReady, the FSM is forced to IDLE, MemErr is set sticky (until Reset), and nothing is captured.
  - Stall drops that cycle.
- Without the macro: no counter; BUSY waits indefinitely; MemErr is tied to 0.

Decomposition:
- Package mips_mc_pkg holds:
  - PCSrc encoding constants: PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP, PCSRC_HOLD.
  - Handshake state typedef {IDLE, BUSY}.
  - Default RESET_PC.
- One sub-module: mips_mem_handshake.
  - Contains the FSM, address latch, Stall, MemRead and the watchdog.
  - The top level keeps the PC, IR and MDR registers and the next-PC mux.

Test Plan:
- Reset, then zero-wait fetch: Reset high → PC = 0, Instr = 0. Release; MemReq = 1, IorD = 0, IRWrite = 1, MemReady = 1, MemRData = 32'h2008_0005 → after one edge Instr = 32'h2008_0005, Stall never 1.
- Two-wait-state fetch: MemReq = 1, MemReady low for 2 cycles → Stall = 1 for 2 cycles with MemAddr held at 0 while IorD toggles; PCWrite = 1 during the stall leaves PC = 0. Third cycle MemReady = 1 → Instr captured, Stall = 0.
- Branch: Branch = 1, ALUOut = 32'h0000_0040, PCSrc = 01.
  - Zero = 0 → PC unchanged.
  - Zero = 1 → PC = 32'h40.
- Jump: PC = 32'h1000_0008, Instr = 32'h0800_0010, PCSrc = 10, PCWrite = 1 → PC = 32'h1000_0040.
- Data load: IorD = 1, ALUOut = 32'h0000_0100, MemRData = 32'hDEAD_BEEF, IRWrite = 0 → MemAddr = 32'h100, Data = 32'hDEAD_BEEF, Instr unchanged.
- Watchdog (macro on, TIMEOUT_CYCLES = 4): MemReady held 0 → MemErr = 1 after 4 BUSY cycles, Stall = 0, FSM IDLE. Mid-BUSY Reset → state IDLE and MemErr = 0.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS fetch front-end:
// PCSrc encodings, the memory handshake state type and the default reset PC.
package mips_mc_pkg;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_HOLD   = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hs_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/mips_mem_handshake.sv
// Memory read handshake for the unified instruction/data port.
// Optional watchdog: define MIPS_MC_FETCH_WATCHDOG_EN to abort reads that
// stay BUSY for TIMEOUT_CYCLES cycles and raise a sticky mem_err.
//
// Handshake: mem_read acts as valid, mem_ready as ready. A read completes on
// any rising edge where mem_read & mem_ready are both high; the address is
// held stable from the first unanswered request cycle until completion.
module mips_mem_handshake
    import mips_mc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        iord,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        stall,
    output logic        complete,
    output logic        mem_err,
    output hs_state_t   state_dbg
);

    hs_state_t   state;
    hs_state_t   state_nxt;
    logic [31:0] addr_q;
    logic        timeout;

    assign state_dbg = state;

    // Handshake state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Capture the address when a request is not answered immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      addr_q <= '0;
        else if (state == IDLE && mem_req && !mem_ready) addr_q <= mem_addr;
    end

`ifdef MIPS_MC_FETCH_WATCHDOG_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd_cnt;

    // Count consecutive BUSY cycles; held at zero while IDLE so entry clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                wd_cnt <= '0;
        else if (state == IDLE) wd_cnt <= '0;
        else                    wd_cnt <= wd_cnt + 8'd1;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          mem_err <= 1'b0;
        else if (timeout) mem_err <= 1'b1;
    end

    assign timeout = (state == BUSY) && !mem_ready && (wd_cnt == TIMEOUT_LAST);
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    // Address select, strobes and next-state logic.
    always_comb begin
        state_nxt = state;
        mem_addr  = iord ? alu_out : pc;
        mem_read  = mem_req | (state == BUSY);
        complete  = mem_read & mem_ready;
        stall     = mem_read & ~mem_ready & ~timeout;
        unique case (state)
            IDLE: if (mem_req && !mem_ready) state_nxt = BUSY;
            BUSY: begin
                mem_addr = addr_q;
                if (mem_ready || timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/mips_mc_fetch_unit.sv
// Multicycle MIPS front-end: PC, instruction register, memory data register
// and next-PC mux, with memory waits handled by mips_mem_handshake.
// Optional watchdog enabled by defining MIPS_MC_FETCH_WATCHDOG_EN.
module mips_mc_fetch_unit
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PCWrite,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        IRWrite,
    input  logic        IorD,
    input  logic [1:0]  PCSrc,
    input  logic        MemReq,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ALUOut,
    input  logic [31:0] MemRData,
    input  logic        MemReady,
    output logic [31:0] MemAddr,
    output logic        MemRead,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic [31:0] Data,
    output logic        Stall,
    output logic        MemErr,
    output hs_state_t   dbg_state
);

    logic        complete;
    logic        pc_en;
    logic [31:0] pc_next;
    logic [31:0] jump_target;

    mips_mem_handshake #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_hs (
        .clk       (Clk),
        .rst       (Reset),
        .mem_req   (MemReq),
        .mem_ready (MemReady),
        .iord      (IorD),
        .pc        (PC),
        .alu_out   (ALUOut),
        .mem_addr  (MemAddr),
        .mem_read  (MemRead),
        .stall     (Stall),
        .complete  (complete),
        .mem_err   (MemErr),
        .state_dbg (dbg_state)
    );

    // PCWrite already implies a write, so Branch only matters when it is low.
    assign pc_en       = (PCWrite | (Branch & Zero)) & ~Stall;
    assign jump_target = {PC[31:28], Instr[25:0], 2'b00};

    // Next-PC select; all arithmetic comes from the ALU.
    always_comb begin
        pc_next = PC;
        unique case (PCSrc)
            PCSRC_ALU:    pc_next = ALUResult;
            PCSRC_ALUOUT: pc_next = ALUOut;
            PCSRC_JUMP:   pc_next = jump_target;
            PCSRC_HOLD:   pc_next = PC;
            default:      pc_next = PC;
        endcase
    end

    // Program counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)      PC <= RESET_PC;
        else if (pc_en) PC <= pc_next;
    end

    // Memory data register loads on every completed read; IR only when asked.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Data  <= '0;
            Instr <= '0;
        end else if (complete) begin
            Data <= MemRData;
            if (IRWrite) Instr <= MemRData;
        end
    end

endmodule

// File: tb/tb_mips_mc_fetch_unit.sv
// Directed testbench for mips_mc_fetch_unit.
module tb_mips_mc_fetch_unit;
    import mips_mc_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        PCWrite, Branch, Zero, IRWrite, IorD, MemReq, MemReady;
    logic [1:0]  PCSrc;
    logic [31:0] ALUResult, ALUOut, MemRData;
    logic [31:0] MemAddr, PC, Instr, Data;
    logic        MemRead, Stall, MemErr;
    hs_state_t   dbg_state;

    int total = 0;
    int bad   = 0;

    mips_mc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
        .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .Branch(Branch), .Zero(Zero),
        .IRWrite(IRWrite), .IorD(IorD), .PCSrc(PCSrc), .MemReq(MemReq),
        .ALUResult(ALUResult), .ALUOut(ALUOut), .MemRData(MemRData),
        .MemReady(MemReady), .MemAddr(MemAddr), .MemRead(MemRead), .PC(PC),
        .Instr(Instr), .Data(Data), .Stall(Stall), .MemErr(MemErr),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 Clk = ~Clk;

    // Driver helpers
    task automatic drive_idle();
        PCWrite = 0; Branch = 0; Zero = 0; IRWrite = 0; IorD = 0; MemReq = 0;
        MemReady = 0; PCSrc = PCSRC_HOLD; ALUResult = '0; ALUOut = '0; MemRData = '0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        #2;
        total++; if (PC !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
        total++; if (Instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want %h", Instr, 32'h0); end
        total++; if (Data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want %h", Data, 32'h0); end
        total++; if (MemErr !== 1'b0) begin bad++; $display("FAIL reset_memerr: got %b want 0", MemErr); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
        tick();
        Reset = 0;
        #1;
    endtask

    task automatic test_zero_wait();
        MemReq = 1; IorD = 0; IRWrite = 1; MemReady = 1; MemRData = 32'h2008_0005;
        #1;
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL zw_stall: got %b want 0", Stall); end
        total++; if (MemRead !== 1'b1) begin bad++; $display("FAIL zw_memread: got %b want 1", MemRead); end
        total++; if (MemAddr !== 32'h0) begin bad++; $display("FAIL zw_addr: got %h want %h", MemAddr, 32'h0); end
        tick();
        total++; if (Instr !== 32'h2008_0005) begin bad++; $display("FAIL zw_instr: got %h want %h", Instr, 32'h2008_0005); end
        total++; if (Data !== 32'h2008_0005) begin bad++; $display("FAIL zw_data: got %h want %h", Data, 32'h2008_0005); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL zw_state: got %0d want IDLE", dbg_state); end
        drive_idle();
    endtask

    task automatic test_wait_states();
        MemReq = 1; IorD = 0; IRWrite = 1; MemReady = 0; MemRData = 32'h1111_2222;
        PCWrite = 1; PCSrc = PCSRC_ALU; ALUResult = 32'h4; ALUOut = 32'h200;
        #1;
        total++; if (Stall !== 1'b1) begin bad++; $display("FAIL ws_stall1: got %b want 1", Stall); end
        total++; if (MemAddr !== 32'h0) begin bad++; $display("FAIL ws_addr1: got %h want %h", MemAddr, 32'h0); end
        tick();
        total++; if (PC !== 32'h0) begin bad++; $display("FAIL ws_pc1: got %h want %h", PC, 32'h0); end
        total++; if (dbg_state !== BUSY) begin bad++; $display("FAIL ws_state1: got %0d want BUSY", dbg_state); end
        IorD = 1;
        #1;
        total++; if (Stall !== 1'b1) begin bad++; $display("FAIL ws_stall2: got %b want 1", Stall); end
        total++; if (MemAddr !== 32'h0) begin bad++; $display("FAIL ws_addr2: got %h want %h", MemAddr, 32'h0); end
        tick();
        total++; if (PC !== 32'h0) begin bad++; $display("FAIL ws_pc2: got %h want %h", PC, 32'h0); end
        total++; if (Instr !== 32'h2008_0005) begin bad++; $display("FAIL ws_instr_hold: got %h want %h", Instr, 32'h2008_0005); end
        IorD = 0; MemReady = 1;
        #1;
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL ws_stall3: got %b want 0", Stall); end
        total++; if (MemAddr !== 32'h0) begin bad++; $display("FAIL ws_addr3: got %h want %h", MemAddr, 32'h0); end
        tick();
        total++; if (Instr !== 32'h1111_2222) begin bad++; $display("FAIL ws_instr: got %h want %h", Instr, 32'h1111_2222); end
        total++; if (PC !== 32'h4) begin bad++; $display("FAIL ws_pc3: got %h want %h", PC, 32'h4); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL ws_state3: got %0d want IDLE", dbg_state); end
        drive_idle();
    endtask

    task automatic test_branch();
        Branch = 1; PCSrc = PCSRC_ALUOUT; ALUOut = 32'h40; Zero = 0;
        tick();
        total++; if (PC !== 32'h4) begin bad++; $display("FAIL br_not_taken: got %h want %h", PC, 32'h4); end
        Zero = 1;
        tick();
        total++; if (PC !== 32'h40) begin bad++; $display("FAIL br_taken: got %h want %h", PC, 32'h40); end
        Zero = 0; PCWrite = 1; PCSrc = PCSRC_ALU; ALUResult = 32'h80;
        tick();
        total++; if (PC !== 32'h80) begin bad++; $display("FAIL br_pcwrite_dom: got %h want %h", PC, 32'h80); end
        Branch = 0; PCSrc = PCSRC_HOLD; ALUResult = 32'h123; ALUOut = 32'h456;
        tick();
        total++; if (PC !== 32'h80) begin bad++; $display("FAIL pc_hold: got %h want %h", PC, 32'h80); end
        drive_idle();
    endtask

    task automatic test_jump();
        PCWrite = 1; PCSrc = PCSRC_ALU; ALUResult = 32'h1000_0008;
        tick();
        total++; if (PC !== 32'h1000_0008) begin bad++; $display("FAIL jmp_setpc: got %h want %h", PC, 32'h1000_0008); end
        drive_idle();
        MemReq = 1; MemReady = 1; IRWrite = 1; MemRData = 32'h0800_0010;
        #1;
        total++; if (MemAddr !== 32'h1000_0008) begin bad++; $display("FAIL jmp_fetch_addr: got %h want %h", MemAddr, 32'h1000_0008); end
        tick();
        drive_idle();
        PCWrite = 1; PCSrc = PCSRC_JUMP;
        tick();
        total++; if (PC !== 32'h1000_0040) begin bad++; $display("FAIL jmp_target: got %h want %h", PC, 32'h1000_0040); end
        drive_idle();
    endtask

    task automatic test_data_load();
        IorD = 1; ALUOut = 32'h100; MemReq = 1; MemReady = 1; IRWrite = 0; MemRData = 32'hDEAD_BEEF;
        #1;
        total++; if (MemAddr !== 32'h100) begin bad++; $display("FAIL ld_addr: got %h want %h", MemAddr, 32'h100); end
        tick();
        total++; if (Data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ld_data: got %h want %h", Data, 32'hDEAD_BEEF); end
        total++; if (Instr !== 32'h0800_0010) begin bad++; $display("FAIL ld_instr_keep: got %h want %h", Instr, 32'h0800_0010); end
        drive_idle();
    endtask

    task automatic test_irwrite_stall_and_reset();
        MemReq = 1; MemReady = 0; IRWrite = 1; MemRData = 32'hCAFE_F00D;
        tick();
        total++; if (Instr !== 32'h0800_0010) begin bad++; $display("FAIL irw_stall_instr: got %h want %h", Instr, 32'h0800_0010); end
        total++; if (Data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL irw_stall_data: got %h want %h", Data, 32'hDEAD_BEEF); end
        total++; if (dbg_state !== BUSY) begin bad++; $display("FAIL irw_stall_state: got %0d want BUSY", dbg_state); end
        MemReady = 1;
        Reset = 1;
        #1;
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rstbusy_state: got %0d want IDLE", dbg_state); end
        total++; if (PC !== 32'h0) begin bad++; $display("FAIL rstbusy_pc: got %h want %h", PC, 32'h0); end
        tick();
        total++; if (Instr !== 32'h0) begin bad++; $display("FAIL rstbusy_instr: got %h want %h", Instr, 32'h0); end
        Reset = 0;
        drive_idle();
        #1;
        total++; if (MemRead !== 1'b0) begin bad++; $display("FAIL rstbusy_memread: got %b want 0", MemRead); end
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL rstbusy_stall: got %b want 0", Stall); end
    endtask

`ifdef MIPS_MC_FETCH_WATCHDOG_EN
    task automatic test_watchdog();
        MemReq = 1; MemReady = 0;
        #1;
        total++; if (Stall !== 1'b1) begin bad++; $display("FAIL wd_stall_req: got %b want 1", Stall); end
        tick();
        MemReq = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (Stall !== 1'b1) begin bad++; $display("FAIL wd_stall_busy%0d: got %b want 1", i, Stall); end
            tick();
        end
        #1;
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL wd_stall_drop: got %b want 0", Stall); end
        total++; if (MemErr !== 1'b0) begin bad++; $display("FAIL wd_err_early: got %b want 0", MemErr); end
        tick();
        total++; if (MemErr !== 1'b1) begin bad++; $display("FAIL wd_err_set: got %b want 1", MemErr); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL wd_state: got %0d want IDLE", dbg_state); end
        total++; if (Data !== 32'h0) begin bad++; $display("FAIL wd_no_capture: got %h want %h", Data, 32'h0); end
        tick();
        total++; if (MemErr !== 1'b1) begin bad++; $display("FAIL wd_err_sticky: got %b want 1", MemErr); end
        MemReq = 1;
        tick();
        MemReq = 0;
        Reset = 1;
        #1;
        total++; if (MemErr !== 1'b0) begin bad++; $display("FAIL wd_rst_err: got %b want 0", MemErr); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL wd_rst_state: got %0d want IDLE", dbg_state); end
        tick();
        Reset = 0;
        drive_idle();
    endtask
`else
    task automatic test_no_watchdog();
        MemReq = 1; MemReady = 0;
        tick();
        MemReq = 0;
        repeat (20) tick();
        total++; if (Stall !== 1'b1) begin bad++; $display("FAIL nowd_stall: got %b want 1", Stall); end
        total++; if (MemErr !== 1'b0) begin bad++; $display("FAIL nowd_err: got %b want 0", MemErr); end
        total++; if (dbg_state !== BUSY) begin bad++; $display("FAIL nowd_state: got %0d want BUSY", dbg_state); end
        MemReady = 1; MemRData = 32'h5555_AAAA;
        #1;
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL nowd_done_stall: got %b want 0", Stall); end
        tick();
        total++; if (Data !== 32'h5555_AAAA) begin bad++; $display("FAIL nowd_data: got %h want %h", Data, 32'h5555_AAAA); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL nowd_idle: got %0d want IDLE", dbg_state); end
        drive_idle();
    endtask
`endif

    // Test sequence and final report
    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branch();
        test_jump();
        test_data_load();
        test_irwrite_stall_and_reset();
`ifdef MIPS_MC_FETCH_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
